// File: rtl/spi_pkg.sv
// Shared definitions for the SPI responder: frame field widths, FSM state
// encoding and command-bit values.
package spi_pkg;

  localparam int unsigned DWIDTH = 8;
  localparam int unsigned AWIDTH = 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CMD  = 3'd1,
    ADDR = 3'd2,
    DATA = 3'd3,
    DONE = 3'd4
  } spi_slv_state_t;

  localparam logic SPI_CMD_READ  = 1'b1;
  localparam logic SPI_CMD_WRITE = 1'b0;

endpackage

// File: rtl/spi_slave_regfile_if.sv
// SPI pin bundle between a master and the clock-domain responder.
//   sck, mosi, ss_n : driven by the master
//   miso, miso_oe   : driven by the responder (miso_oe marks active drive)
interface spi_slave_regfile_if;

  logic sck;
  logic mosi;
  logic ss_n;
  logic miso;
  logic miso_oe;

  modport master (output sck, mosi, ss_n, input miso, miso_oe);
  modport slave  (input sck, mosi, ss_n, output miso, miso_oe);

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer with rise/fall detection on the synchronized level.
//   clk, rst_n : system clock, async active-low reset (chain clears to 0)
//   d          : asynchronous input
//   q          : synchronized level
//   rise, fall : single-cycle pulses on synchronized transitions
module spi_sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              q_d;

  // Clearing to 0 means a select held low through reset never looks like a
  // fresh falling edge, so a frame cut by reset cannot restart mid-way.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
      q_d   <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      q_d   <= chain[STAGES-1];
    end
  end

  assign q    = chain[STAGES-1];
  assign rise = q & ~q_d;
  assign fall = ~q & q_d;

endmodule

// File: rtl/spi_slave_regfile.sv
// SPI responder running entirely on clk. Oversamples the SPI pins, decodes
// {cmd, addr, data} frames MSB first, writes or reads a local register file.
//   clk, rst_n          : system clock, async active-low reset
//   driver_cfg          : {CPOL, CPHA}, static while ss_n is low
//   spi                 : SPI pins (slave modport)
//   wr_strobe           : one-cycle pulse on write commit
//   wr_addr, wr_data    : last committed write
//   frame_err           : one-cycle pulse when ss_n rises mid-frame
//   busy                : frame in progress
//   loc_addr, loc_data  : combinational local read port
module spi_slave_regfile
  import spi_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         driver_cfg,
  spi_slave_regfile_if.slave spi,
  output logic               wr_strobe,
  output logic [AWIDTH-1:0]  wr_addr,
  output logic [DWIDTH-1:0]  wr_data,
  output logic               frame_err,
  output logic               busy,
  input  logic [AWIDTH-1:0]  loc_addr,
  output logic [DWIDTH-1:0]  loc_data
);

  localparam int unsigned NREGS = 2 ** AWIDTH;
  localparam int unsigned MAXW  = (AWIDTH > DWIDTH) ? AWIDTH : DWIDTH;
  localparam int unsigned CNT_W = (MAXW > 1) ? $clog2(MAXW) : 1;
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(AWIDTH - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DWIDTH - 1);

  logic sck_q, sck_rise, sck_fall;
  logic ss_q, ss_rise, ss_fall;
  logic [SYNC_STAGES-1:0] mosi_chain;
  logic mosi_s;

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sck_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (spi.sck),
    .q    (sck_q),
    .rise (sck_rise),
    .fall (sck_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_ss_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (spi.ss_n),
    .q    (ss_q),
    .rise (ss_rise),
    .fall (ss_fall)
  );

  // mosi only needs its level; it shares the sck chain depth so both line up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mosi_chain <= '0;
    end else begin
      mosi_chain <= {mosi_chain[SYNC_STAGES-2:0], spi.mosi};
    end
  end
  assign mosi_s = mosi_chain[SYNC_STAGES-1];

  // An edge is leading when sck has just moved away from its idle level.
  logic cpol, cpha, sck_edge, lead_edge, trail_edge, sample_edge, shift_edge;
  assign cpol        = driver_cfg[1];
  assign cpha        = driver_cfg[0];
  assign sck_edge    = sck_rise | sck_fall;
  assign lead_edge   = sck_edge & (sck_q ^ cpol);
  assign trail_edge  = sck_edge & ~(sck_q ^ cpol);
  assign sample_edge = cpha ? trail_edge : lead_edge;
  assign shift_edge  = cpha ? lead_edge : trail_edge;

  spi_slv_state_t    state;
  logic [CNT_W-1:0]  cnt;
  logic              cmd;
  logic [AWIDTH-1:0] addr_sr;
  logic [DWIDTH-1:0] rx_sr;
  logic [DWIDTH-1:0] tx_sr;
  logic              tx_bit;
  logic              drive;
  logic [DWIDTH-1:0] regs [NREGS];

  logic [AWIDTH-1:0] addr_next;
  logic [DWIDTH-1:0] data_next;
  logic              in_frame;
  assign addr_next = AWIDTH'({addr_sr, mosi_s});
  assign data_next = DWIDTH'({rx_sr, mosi_s});
  assign in_frame  = (state == CMD) || (state == ADDR) || (state == DATA);

  // Frame decoder, register file and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      cmd       <= SPI_CMD_WRITE;
      addr_sr   <= '0;
      rx_sr     <= '0;
      tx_sr     <= '0;
      tx_bit    <= 1'b0;
      drive     <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
      regs      <= '{default: '0};
    end else begin
      wr_strobe <= 1'b0;
      frame_err <= 1'b0;
      if (in_frame && ss_rise) begin
        // Early deselect: abort without committing anything.
        state     <= IDLE;
        frame_err <= 1'b1;
        drive     <= 1'b0;
        tx_bit    <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (ss_fall) begin
              state <= CMD;
              cnt   <= '0;
              busy  <= 1'b1;
            end
          end
          CMD: begin
            if (sample_edge) begin
              cmd   <= mosi_s;
              cnt   <= '0;
              state <= ADDR;
            end
          end
          ADDR: begin
            if (sample_edge) begin
              addr_sr <= addr_next;
              if (cnt == ADDR_LAST) begin
                cnt   <= '0;
                state <= DATA;
                if (cmd == SPI_CMD_READ) begin
                  tx_sr <= regs[addr_next];
                end
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end
          end
          DATA: begin
            if ((cmd == SPI_CMD_READ) && shift_edge) begin
              tx_bit <= tx_sr[DWIDTH-1];
              tx_sr  <= tx_sr << 1;
              drive  <= 1'b1;
            end
            if (sample_edge) begin
              rx_sr <= data_next;
              if (cnt == DATA_LAST) begin
                state <= DONE;
                if (cmd == SPI_CMD_WRITE) begin
                  regs[addr_sr] <= data_next;
                  wr_addr       <= addr_sr;
                  wr_data       <= data_next;
                  wr_strobe     <= 1'b1;
                end
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end
          end
          DONE: begin
            // miso keeps the last bit until deselect.
            if (ss_q) begin
              state  <= IDLE;
              drive  <= 1'b0;
              tx_bit <= 1'b0;
              busy   <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Pin output stage; miso is forced low whenever it is not driven.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spi.miso    <= 1'b0;
      spi.miso_oe <= 1'b0;
    end else begin
      spi.miso    <= drive & tx_bit;
      spi.miso_oe <= drive;
    end
  end

  assign loc_data = regs[loc_addr];

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Self-checking bench for spi_slave_regfile: a bit-banged SPI master in all
// four modes, a register-file reference model and a write-event scoreboard.
module tb_spi_slave_regfile;
  import spi_pkg::*;

  localparam int FLEN = 1 + AWIDTH + DWIDTH;

  logic              clk;
  logic              rst_n;
  logic [1:0]        driver_cfg;
  logic              wr_strobe;
  logic [AWIDTH-1:0] wr_addr;
  logic [DWIDTH-1:0] wr_data;
  logic              frame_err;
  logic              busy;
  logic [AWIDTH-1:0] loc_addr;
  logic [DWIDTH-1:0] loc_data;

  spi_slave_regfile_if sif ();

  spi_slave_regfile #(.SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .driver_cfg(driver_cfg),
    .spi       (sif),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .frame_err (frame_err),
    .busy      (busy),
    .loc_addr  (loc_addr),
    .loc_data  (loc_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [DWIDTH-1:0] model [2**AWIDTH];
  int n_strobe = 0;
  int n_ferr   = 0;
  logic [AWIDTH+DWIDTH-1:0] wq [$];

  // Event monitor: record every committed write and every abort pulse.
  always @(negedge clk) begin
    if (wr_strobe === 1'b1) begin
      n_strobe++;
      wq.push_back({wr_addr, wr_data});
    end
    if (frame_err === 1'b1) n_ferr++;
  end

  // Bit-banged master, sck = clk/8. Returns captured read data and the number
  // of sample points where miso_oe/miso disagreed with the expected window.
  task automatic spi_xfer(input logic [1:0] mode, input logic rd,
                          input logic [AWIDTH-1:0] a, input logic [DWIDTH-1:0] d,
                          input int nsamp, input int gap,
                          output logic [DWIDTH-1:0] cap, output int oe_bad);
    logic [FLEN-1:0] fr;
    logic cpol, cpha, oe_exp;
    fr = {rd, a, d};
    cpol = mode[1];
    cpha = mode[0];
    cap = '0;
    oe_bad = 0;
    driver_cfg = mode;
    sif.sck = cpol;
    sif.mosi = 1'b0;
    repeat (gap) @(negedge clk);
    sif.ss_n = 1'b0;
    if (!cpha) sif.mosi = fr[FLEN-1];
    repeat (4) @(negedge clk);
    for (int i = 0; i < nsamp; i++) begin
      oe_exp = rd && (i > AWIDTH);
      if (!cpha) begin
        if (i > AWIDTH) cap = {cap[DWIDTH-2:0], sif.miso};
        if (sif.miso_oe !== oe_exp) oe_bad++;
        sif.sck = ~cpol;
        repeat (4) @(negedge clk);
        sif.sck = cpol;
        if (i < FLEN - 1) sif.mosi = fr[FLEN-2-i];
        repeat (4) @(negedge clk);
      end else begin
        sif.sck = ~cpol;
        sif.mosi = fr[FLEN-1-i];
        repeat (4) @(negedge clk);
        if (i > AWIDTH) cap = {cap[DWIDTH-2:0], sif.miso};
        if (sif.miso_oe !== oe_exp) oe_bad++;
        sif.sck = cpol;
        repeat (4) @(negedge clk);
      end
    end
    if (rd && nsamp == FLEN && sif.miso_oe !== 1'b1) oe_bad++;
    sif.ss_n = 1'b1;
    repeat (4) @(negedge clk);
    if (sif.miso_oe !== 1'b0 || sif.miso !== 1'b0) oe_bad++;
  endtask

  task automatic test_reset();
    int bad;
    rst_n = 1'b0;
    driver_cfg = 2'b00;
    sif.sck = 1'b0;
    sif.mosi = 1'b0;
    sif.ss_n = 1'b1;
    loc_addr = '0;
    for (int i = 0; i < 2**AWIDTH; i++) model[i] = '0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (wr_strobe !== 1'b0) begin failures++; $display("FAIL reset_wr_strobe: got %b expected 0", wr_strobe); end
    checks++; if (wr_addr !== '0) begin failures++; $display("FAIL reset_wr_addr: got %h expected 0", wr_addr); end
    checks++; if (wr_data !== '0) begin failures++; $display("FAIL reset_wr_data: got %h expected 0", wr_data); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (sif.miso !== 1'b0) begin failures++; $display("FAIL reset_miso: got %b expected 0", sif.miso); end
    checks++; if (sif.miso_oe !== 1'b0) begin failures++; $display("FAIL reset_miso_oe: got %b expected 0", sif.miso_oe); end
    bad = 0;
    for (int i = 0; i < 2**AWIDTH; i++) begin
      loc_addr = AWIDTH'(i);
      #1;
      if (loc_data !== model[i]) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL reset_regs: got %0d nonzero entries expected 0", bad); end
  endtask

  task automatic test_write_mode0();
    logic [DWIDTH-1:0] cap;
    logic [AWIDTH+DWIDTH-1:0] ev;
    int ob, s0;
    s0 = n_strobe;
    spi_xfer(2'b00, SPI_CMD_WRITE, 4'h3, 8'hA5, FLEN, 8, cap, ob);
    model[3] = 8'hA5;
    checks++; if (n_strobe - s0 != 1) begin failures++; $display("FAIL write0_strobe_count: got %0d expected 1", n_strobe - s0); end
    ev = (wq.size() > 0) ? wq.pop_front() : '1;
    checks++; if (ev !== {4'h3, 8'hA5}) begin failures++; $display("FAIL write0_event: got %h expected %h", ev, {4'h3, 8'hA5}); end
    checks++; if (wr_addr !== 4'h3 || wr_data !== 8'hA5) begin failures++; $display("FAIL write0_wr_regs: got %h/%h expected 3/a5", wr_addr, wr_data); end
    loc_addr = 4'h3;
    #1;
    checks++; if (loc_data !== model[3]) begin failures++; $display("FAIL write0_loc_data: got %h expected %h", loc_data, model[3]); end
    checks++; if (ob != 0) begin failures++; $display("FAIL write0_miso_oe: got %0d bad samples expected 0", ob); end
  endtask

  task automatic test_read_modes();
    logic [DWIDTH-1:0] cap;
    int ob, s0;
    for (int m = 0; m < 4; m++) begin
      s0 = n_strobe;
      spi_xfer(2'(m), SPI_CMD_READ, 4'h3, 8'h00, FLEN, 8, cap, ob);
      checks++; if (cap !== model[3]) begin failures++; $display("FAIL read_mode%0d_data: got %h expected %h", m, cap, model[3]); end
      checks++; if (ob != 0) begin failures++; $display("FAIL read_mode%0d_miso_oe: got %0d bad samples expected 0", m, ob); end
      checks++; if (n_strobe != s0) begin failures++; $display("FAIL read_mode%0d_no_write: got %0d strobes expected 0", m, n_strobe - s0); end
    end
  endtask

  task automatic test_read_unwritten();
    logic [DWIDTH-1:0] cap;
    int ob;
    spi_xfer(2'b00, SPI_CMD_READ, 4'hF, 8'hFF, FLEN, 8, cap, ob);
    checks++; if (cap !== model[15]) begin failures++; $display("FAIL read_unwritten: got %h expected %h", cap, model[15]); end
  endtask

  task automatic test_abort();
    logic [DWIDTH-1:0] cap;
    int ob, s0, f0;
    s0 = n_strobe;
    f0 = n_ferr;
    spi_xfer(2'b00, SPI_CMD_WRITE, 4'h1, 8'h3C, 1 + AWIDTH + 6, 8, cap, ob);
    repeat (4) @(negedge clk);
    checks++; if (n_ferr - f0 != 1) begin failures++; $display("FAIL abort_frame_err: got %0d pulses expected 1", n_ferr - f0); end
    checks++; if (n_strobe != s0) begin failures++; $display("FAIL abort_no_strobe: got %0d strobes expected 0", n_strobe - s0); end
    loc_addr = 4'h1;
    #1;
    checks++; if (loc_data !== model[1]) begin failures++; $display("FAIL abort_reg_unchanged: got %h expected %h", loc_data, model[1]); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy: got %b expected 0", busy); end
  endtask

  task automatic test_reset_midframe();
    logic [DWIDTH-1:0] cap, d;
    logic [AWIDTH-1:0] a;
    logic [1:0] m;
    logic [AWIDTH+DWIDTH-1:0] ev;
    int ob, s0, f0, bad;
    driver_cfg = 2'b00;
    sif.sck = 1'b0;
    sif.ss_n = 1'b1;
    repeat (8) @(negedge clk);
    sif.ss_n = 1'b0;
    sif.mosi = SPI_CMD_WRITE;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      sif.sck = 1'b1;
      repeat (4) @(negedge clk);
      sif.sck = 1'b0;
      sif.mosi = 1'($urandom);
      repeat (4) @(negedge clk);
    end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midrst_busy_before: got %b expected 1", busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || sif.miso_oe !== 1'b0) begin failures++; $display("FAIL midrst_async: got busy=%b oe=%b expected 0/0", busy, sif.miso_oe); end
    for (int i = 0; i < 2**AWIDTH; i++) model[i] = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    s0 = n_strobe;
    f0 = n_ferr;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      sif.sck = 1'b1;
      sif.mosi = 1'($urandom);
      repeat (4) begin @(negedge clk); if (busy !== 1'b0) bad++; end
      sif.sck = 1'b0;
      repeat (4) begin @(negedge clk); if (busy !== 1'b0) bad++; end
    end
    sif.ss_n = 1'b1;
    repeat (8) @(negedge clk);
    checks++; if (bad != 0) begin failures++; $display("FAIL midrst_busy_after: got %0d busy cycles expected 0", bad); end
    checks++; if (n_strobe != s0 || n_ferr != f0) begin failures++; $display("FAIL midrst_no_events: got %0d strobes %0d errs expected 0", n_strobe - s0, n_ferr - f0); end
    loc_addr = 4'h3;
    #1;
    checks++; if (loc_data !== model[3]) begin failures++; $display("FAIL midrst_regs_cleared: got %h expected %h", loc_data, model[3]); end
    m = 2'($urandom);
    a = AWIDTH'($urandom);
    d = DWIDTH'($urandom);
    spi_xfer(m, SPI_CMD_WRITE, a, d, FLEN, 8, cap, ob);
    model[a] = d;
    ev = (wq.size() > 0) ? wq.pop_front() : ~{a, d};
    checks++; if (ev !== {a, d}) begin failures++; $display("FAIL midrst_next_frame: got %h expected %h", ev, {a, d}); end
    spi_xfer(m, SPI_CMD_READ, a, 8'h00, FLEN, 8, cap, ob);
    checks++; if (cap !== model[a]) begin failures++; $display("FAIL midrst_readback: got %h expected %h", cap, model[a]); end
  endtask

  task automatic test_back_to_back();
    logic [DWIDTH-1:0] cap;
    logic [AWIDTH+DWIDTH-1:0] ev0, ev1;
    int ob, s0;
    s0 = n_strobe;
    spi_xfer(2'b00, SPI_CMD_WRITE, 4'h0, 8'h11, FLEN, 8, cap, ob);
    spi_xfer(2'b00, SPI_CMD_WRITE, 4'hE, 8'h22, FLEN, 0, cap, ob);
    model[0] = 8'h11;
    model[14] = 8'h22;
    checks++; if (n_strobe - s0 != 2) begin failures++; $display("FAIL b2b_strobe_count: got %0d expected 2", n_strobe - s0); end
    ev0 = (wq.size() > 0) ? wq.pop_front() : '1;
    ev1 = (wq.size() > 0) ? wq.pop_front() : '1;
    checks++; if (ev0 !== {4'h0, 8'h11} || ev1 !== {4'hE, 8'h22}) begin failures++; $display("FAIL b2b_order: got %h,%h expected 011,e22", ev0, ev1); end
    loc_addr = 4'h0;
    #1;
    checks++; if (loc_data !== model[0]) begin failures++; $display("FAIL b2b_reg0: got %h expected %h", loc_data, model[0]); end
    loc_addr = 4'hE;
    #1;
    checks++; if (loc_data !== model[14]) begin failures++; $display("FAIL b2b_reg14: got %h expected %h", loc_data, model[14]); end
  endtask

  task automatic test_random();
    logic [DWIDTH-1:0] cap, d;
    logic [AWIDTH-1:0] a;
    logic [1:0] m;
    logic rd;
    logic [AWIDTH+DWIDTH-1:0] ev;
    int ob, s0, bad;
    for (int t = 0; t < 20; t++) begin
      m = 2'($urandom);
      rd = 1'($urandom);
      a = AWIDTH'($urandom);
      d = DWIDTH'($urandom);
      s0 = n_strobe;
      spi_xfer(m, rd, a, d, FLEN, 8, cap, ob);
      checks++; if (ob != 0) begin failures++; $display("FAIL rand%0d_miso_oe: got %0d bad samples expected 0", t, ob); end
      if (rd) begin
        checks++; if (cap !== model[a]) begin failures++; $display("FAIL rand%0d_read: got %h expected %h (mode %0d addr %h)", t, cap, model[a], m, a); end
      end else begin
        model[a] = d;
        ev = (wq.size() > 0) ? wq.pop_front() : ~{a, d};
        checks++; if (n_strobe - s0 != 1 || ev !== {a, d}) begin failures++; $display("FAIL rand%0d_write: got %h x%0d expected %h x1", t, ev, n_strobe - s0, {a, d}); end
      end
    end
    bad = 0;
    for (int i = 0; i < 2**AWIDTH; i++) begin
      loc_addr = AWIDTH'(i);
      #1;
      if (loc_data !== model[i]) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL rand_final_regs: got %0d differing entries expected 0", bad); end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_mode0();
    test_read_modes();
    test_read_unwritten();
    test_abort();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_slave_regfile.md
# spi_slave_regfile

Clock-domain SPI responder. It oversamples `sck`, `mosi` and `ss_n` with the system clock and decodes command/address/data frames from `spi_master`. Write frames update a local register file; read frames return register contents on `miso`. It replaces the sck-clocked slave model on `ss_n[0]` in the system and is intended for synthesis.

## Interface
- `SYNC_STAGES`, default 2: synchronizer depth for `sck`, `mosi` and `ss_n`; must be at least 2.
- `DWIDTH`, `AWIDTH`: taken from `spi_pkg`, not overridden locally.
- `clk`  in  1  system clock; the block uses this single clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `driver_cfg`  in  2  SPI mode: bit1 = CPOL, bit0 = CPHA. Must be static while `ss_n` is low.
- `sck`  in  1  SPI clock, asynchronous to `clk`.
- `mosi`  in  1  serial data in, MSB first.
- `ss_n`  in  1  active-low select.
- `miso`  out  1  serial data out; 0 when not driving.
- `miso_oe`  out  1  high while `miso` is actively driven (read data phase only).
- `wr_strobe`  out  1  one-cycle pulse when a register write commits.
- `wr_addr`  out  AWIDTH  address of the last committed write.
- `wr_data`  out  DWIDTH  data of the last committed write.
- `frame_err`  out  1  one-cycle pulse when a frame aborts early.
- `busy`  out  1  high while a frame is in progress.
- `loc_addr`  in  AWIDTH  local combinational read address.
- `loc_data`  out  DWIDTH  `regs[loc_addr]`, combinational.

## Operation
- Frame format, in order, MSB first:
  - 1 command bit: 1 = read, 0 = write.
  - AWIDTH address bits.
  - DWIDTH data bits.
  - Total frame length is 1+AWIDTH+DWIDTH sample edges.
- Edge definitions:
  - Leading edge = `sck` leaving its idle level (CPOL); trailing edge = the opposite transition.
  - CPHA=0: sample on leading edges, shift on trailing edges.
  - CPHA=1: shift on leading edges, sample on trailing edges.
  - All edges are detected on the synchronized `sck`.
- Register file: 2**AWIDTH entries of DWIDTH bits, all reset to 0.
- FSM states, with a bit counter wide enough for max(AWIDTH, DWIDTH):
  - IDLE: on synchronized `ss_n` falling edge, clear counter and go to CMD. A low `ss_n` without a falling edge does not start a frame.
  - CMD: first sample edge latches the command bit, then go to ADDR.
  - ADDR: shift AWIDTH bits.
    - On the last address sample, a read frame loads `regs[addr]` into the tx shift register.
    - Then go to DATA.
  - DATA, write frame: shift DWIDTH bits into the rx register. On the last sample, write `regs[addr]`, update `wr_addr`/`wr_data`, pulse `wr_strobe`, go to DONE.
  - DATA, read frame:
    - The first shift edge after the last address sample drives the tx MSB and raises `miso_oe`.
    - Each later shift edge drives the next bit.
    - The last data sample edge goes to DONE; `miso` holds the final bit until `ss_n` rises.
  - DONE: ignore further edges; go to IDLE on `ss_n` high.
- `ss_n` rising in CMD, ADDR or DATA:
  - Pulse `frame_err` and go to IDLE.
  - No register write occurs.
  - `miso_oe` drops to 0.
- `busy` is 1 in CMD, ADDR, DATA and DONE.
- A write to address A at the same cycle `loc_addr` = A: `loc_data` shows the new value from the next cycle.

## Timing
- Reset values:
  - `miso` = 0, `miso_oe` = 0, `wr_strobe` = 0, `wr_addr` = 0, `wr_data` = 0, `frame_err` = 0, `busy` = 0.
  - FSM = IDLE, all `regs` = 0.
- Input-to-action latency: SYNC_STAGES + 1 `clk` cycles from pin edge to FSM action (3 at default). Write commit and `wr_strobe` follow the final pin sample edge by this latency.
- `miso` changes SYNC_STAGES + 2 cycles after the pin shift edge.
- Required `sck` rate: f_clk/8 or slower; `ss_n` setup/hold to the first/last `sck` edge of at least 4 `clk` cycles. Faster clocks are out of contract.
- Reset asserted mid-frame:
  - All outputs return to reset values immediately (asynchronous).
  - The remainder of that frame is ignored, because a new frame needs a fresh `ss_n` falling edge.

## Structure
- `spi_pkg` holds:
  - DWIDTH and AWIDTH, extended with `spi_slv_state_t` (IDLE, CMD, ADDR, DATA, DONE).
  - Constants `SPI_CMD_READ` = 1 and `SPI_CMD_WRITE` = 0.
- One sub-module, `spi_sync_edge`: a SYNC_STAGES flop chain plus rise/fall detect. It is instantiated for `sck` and `ss_n`; `mosi` uses the chain only.

## Test plan
Run with DWIDTH=8, AWIDTH=4, sck = clk/8.
- Mode 0, write 0xA5 to address 0x3 -> one `wr_strobe` with `wr_addr`=0x3, `wr_data`=0xA5; `loc_addr`=0x3 reads 0xA5.
- Mode 0, then modes 1, 2 and 3, read address 0x3 after the write above -> master captures 0xA5 in each mode; `miso_oe` is high only during the 8 data bits and until `ss_n` rises.
- Read of the never-written address 0xF -> returns 0x00.
- `ss_n` deasserted after 6 data bits of a write of 0x3C to address 0x1 -> one `frame_err` pulse, no `wr_strobe`, `regs[1]` unchanged.
- `rst_n` asserted during the ADDR phase, then released while `ss_n` is still low, with `sck` continuing -> no writes and `busy` stays 0; the next full frame is decoded correctly.
- Back-to-back writes 0x11 to address 0x0 and 0x22 to address 0xE with 4 `clk` cycles of `ss_n` high between them -> two `wr_strobe` pulses in order, and both registers hold the correct values.
